// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the configuration register with UART read-back.
// Checksum byte is enabled by defining UART_CFG_CHECKSUM_EN.
package uart_cfg_pkg;

  localparam logic [7:0] CFG_HDR = 8'hA5;

  typedef enum logic [1:0] {
    LOAD,
    IDLE,
    SNAP,
    SEND
  } cfg_state_e;

  // Rounded clocks-per-bit divisor.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with its own baud counter. A start issued in the last
// clock of a stop bit continues the line back to back. DIV must be >= 2.
module uart_tx_byte #(
  parameter int unsigned DIV = 87
) (
  input  logic       clk10mhz,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned   BW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] LAST_TICK = BW'(DIV - 1);
  localparam logic [BW-1:0] DONE_TICK = BW'(DIV - 2);

  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shf_q, shf_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge clk10mhz or posedge rst) begin
    if (rst) begin
      baud_q <= '0;
      bit_q  <= '0;
      shf_q  <= '1;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      shf_q  <= shf_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Bit sequencing; done marks the final clock of the stop bit.
  always_comb begin
    baud_d = baud_q;
    bit_d  = bit_q;
    shf_d  = shf_q;
    tx_d   = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      tx_d   = 1'b0;
      busy_d = 1'b1;
      baud_d = '0;
      bit_d  = '0;
      shf_d  = {1'b1, data};
    end else if (busy_q) begin
      if (baud_q == LAST_TICK) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          tx_d  = shf_q[0];
          shf_d = {1'b1, shf_q[8:1]};
        end
      end else begin
        baud_d = baud_q + BW'(1);
        if (bit_q == 4'd9 && baud_q == DONE_TICK) done_d = 1'b1;
      end
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/uart_config_show_gen.sv
// Configuration register with framed UART read-back (header, payload MSB
// first, optional checksum when UART_CFG_CHECKSUM_EN is defined).
module uart_config_show_gen
  import uart_cfg_pkg::*;
#(
  parameter int unsigned BUS_BYTES     = 1,
  parameter int unsigned CLK_HZ        = 10_000_000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned REPORT_PERIOD = 1_000_000
) (
  input  logic                   clk10mhz,
  input  logic                   rst,
  input  logic [8*BUS_BYTES-1:0] busDefault,
  output logic [8*BUS_BYTES-1:0] busNow,
  input  logic                   setValid,
  input  logic [8*BUS_BYTES-1:0] setData,
  input  logic                   showReq,
  output logic                   uTx,
  output logic                   txBusy,
  output logic                   frameDone
);

  localparam int unsigned W    = 8 * BUS_BYTES;
  localparam int unsigned DIV  = baud_div(CLK_HZ, BAUD);
`ifdef UART_CFG_CHECKSUM_EN
  localparam int unsigned CSUM = 1;
`else
  localparam int unsigned CSUM = 0;
`endif
  localparam int unsigned   NBYTES   = 1 + BUS_BYTES + CSUM;
  localparam int unsigned   IW       = $clog2(NBYTES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam bit            PER_EN   = (REPORT_PERIOD != 0);
  localparam int unsigned   PW       = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'((REPORT_PERIOD == 0) ? 0 : REPORT_PERIOD - 1);

  cfg_state_e    state_q, state_d;
  logic [W-1:0]  bus_q, bus_d;
  logic [W-1:0]  snap_q, snap_d;
  logic          pend_q, pend_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [PW-1:0] per_q, per_d;
  logic          fdone_q, fdone_d;

  logic          start_c;
  logic [7:0]    tx_data_c;
  logic [IW-1:0] next_idx_c;
  logic [7:0]    pay_byte_c;
  logic          per_hit_c;
  logic          byte_done;

  always_ff @(posedge clk10mhz or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      bus_q   <= '0;
      snap_q  <= '0;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      csum_q  <= '0;
      per_q   <= '0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      per_q   <= per_d;
      fdone_q <= fdone_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bus_d      = bus_q;
    snap_d     = snap_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    per_d      = per_q;
    fdone_d    = 1'b0;
    per_hit_c  = 1'b0;
    start_c    = 1'b0;
    tx_data_c  = CFG_HDR;
    next_idx_c = idx_q + IW'(1);
    pay_byte_c = '0;

    // Payload byte for the next index; index 1 is the most significant byte.
    for (int i = 0; i < int'(BUS_BYTES); i++) begin
      if (next_idx_c == IW'(i + 1)) pay_byte_c = snap_q[8*(int'(BUS_BYTES)-1-i) +: 8];
    end

    if (PER_EN) begin
      per_hit_c = (per_q == PER_LAST);
      per_d     = per_hit_c ? '0 : per_q + PW'(1);
    end

    if (setValid) bus_d = setData;

    case (state_q)
      LOAD: begin
        if (!setValid) bus_d = busDefault;
        pend_d  = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        if (pend_q) state_d = SNAP;
      end
      SNAP: begin
        snap_d    = bus_q;
        pend_d    = 1'b0;
        start_c   = 1'b1;
        tx_data_c = CFG_HDR;
        idx_d     = '0;
        csum_d    = '0;
        state_d   = SEND;
      end
      SEND: begin
        if (byte_done) begin
          if (idx_q == LAST_IDX) begin
            fdone_d = 1'b1;
            state_d = IDLE;
          end else begin
            start_c = 1'b1;
            idx_d   = next_idx_c;
            csum_d  = csum_q + pay_byte_c;
`ifdef UART_CFG_CHECKSUM_EN
            tx_data_c = (next_idx_c == LAST_IDX) ? csum_q : pay_byte_c;
`else
            tx_data_c = pay_byte_c;
`endif
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Triggers collapse into one pending frame; a trigger during SNAP re-arms it.
    if (showReq || setValid || per_hit_c) pend_d = 1'b1;
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk10mhz(clk10mhz),
    .rst     (rst),
    .start   (start_c),
    .data    (tx_data_c),
    .tx      (uTx),
    .busy    (txBusy),
    .done    (byte_done)
  );

  assign busNow    = bus_q;
  assign frameDone = fdone_q;

endmodule

// File: tb/tb_uart_config_show_gen.sv
// Randomised bench: UART line decoders rebuild frames and compare them with
// frames computed from the header/payload/checksum rules.
module tb_uart_config_show_gen;

  localparam int DIV = 87;
`ifdef UART_CFG_CHECKSUM_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif

  logic clk = 1'b0;
  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a = 1'b1, setv_a = 1'b0, show_a = 1'b0;
  logic [7:0]  busdef_a = 8'h3C, setd_a = 8'h00;
  logic [7:0]  busnow_a;
  logic        utx_a, busy_a, fdone_a;

  logic        rst_b = 1'b1, setv_b = 1'b0, show_b = 1'b0;
  logic [15:0] busdef_b = 16'h1234, setd_b = 16'h0000;
  logic [15:0] busnow_b;
  logic        utx_b, busy_b, fdone_b;

  uart_config_show_gen #(.BUS_BYTES(1), .REPORT_PERIOD(0)) dut_a (
    .clk10mhz(clk), .rst(rst_a), .busDefault(busdef_a), .busNow(busnow_a),
    .setValid(setv_a), .setData(setd_a), .showReq(show_a),
    .uTx(utx_a), .txBusy(busy_a), .frameDone(fdone_a)
  );

  uart_config_show_gen #(.BUS_BYTES(2), .REPORT_PERIOD(5000)) dut_b (
    .clk10mhz(clk), .rst(rst_b), .busDefault(busdef_b), .busNow(busnow_b),
    .setValid(setv_b), .setData(setd_b), .showReq(show_b),
    .uTx(utx_b), .txBusy(busy_b), .frameDone(fdone_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Expected frame packed with the first transmitted byte most significant.
  function automatic logic [63:0] mkframe(input logic [63:0] v, input int nb);
    logic [63:0] f;
    logic [7:0]  b, sum;
    f   = 64'hA5;
    sum = 8'h00;
    for (int i = nb - 1; i >= 0; i--) begin
      b   = v[8*i +: 8];
      f   = (f << 8) | 64'(b);
      sum = sum + b;
    end
    if (C != 0) f = (f << 8) | 64'(sum);
    return f;
  endfunction

  logic [63:0] fa[$], fb[$];
  int          sa[$], sb[$];

  function automatic logic tx_of(input int inst);
    return (inst != 0) ? utx_b : utx_a;
  endfunction
  function automatic logic rst_of(input int inst);
    return (inst != 0) ? rst_b : rst_a;
  endfunction
  function automatic logic busy_of(input int inst);
    return (inst != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic fdone_of(input int inst);
    return (inst != 0) ? fdone_b : fdone_a;
  endfunction
  function automatic int nfr(input int inst);
    return (inst != 0) ? fb.size() : fa.size();
  endfunction

  // Line decoder: samples first and last clock of every bit; aborts on reset.
  task automatic monitor(input int inst);
    int          nb, s;
    logic        ab, wbad, sbad, pbad, first, last;
    logic [7:0]  by;
    logic [63:0] f;
    nb = 1 + ((inst != 0) ? 2 : 1) + C;
    forever begin
      @(negedge clk);
      if (!rst_of(inst) && tx_of(inst) == 1'b0) begin
        s = cyc; ab = 1'b0; wbad = 1'b0; sbad = 1'b0; pbad = 1'b0; f = '0; by = '0;
        check($sformatf("busy_rise%0d", inst), 64'(busy_of(inst)), 64'd1);
        for (int b = 0; b < nb && !ab; b++) begin
          for (int k = 0; k < 10 && !ab; k++) begin
            first = tx_of(inst);
            for (int j = 0; j < DIV - 1 && !ab; j++) begin
              @(negedge clk);
              ab = rst_of(inst);
            end
            last = tx_of(inst);
            if (first !== last) wbad = 1'b1;
            if (k == 0 && first !== 1'b0) sbad = 1'b1;
            if (k == 9 && first !== 1'b1) pbad = 1'b1;
            if (k >= 1 && k <= 8) by[k-1] = first;
            @(negedge clk);
            if (rst_of(inst)) ab = 1'b1;
          end
          f = (f << 8) | 64'(by);
        end
        if (!ab) begin
          check($sformatf("bit_width%0d", inst), 64'(wbad), 64'd0);
          check($sformatf("start_bits%0d", inst), 64'(sbad), 64'd0);
          check($sformatf("stop_bits%0d", inst), 64'(pbad), 64'd0);
          check($sformatf("frame_done%0d@%0d", inst, cyc - s), 64'(fdone_of(inst)), 64'd1);
          check($sformatf("busy_fall%0d", inst), 64'(busy_of(inst)), 64'd0);
          if (inst != 0) begin fb.push_back(f); sb.push_back(s); end
          else begin fa.push_back(f); sa.push_back(s); end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_frames(input int inst, input int n);
    int cnt = 0;
    while (nfr(inst) < n && cnt < 12000) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("wait_frames%0d_n%0d", inst, n), 64'(nfr(inst) >= n), 64'd1);
  endtask

  task automatic wait_busy_a();
    int cnt = 0;
    while (!busy_a && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("wait_busy", 64'(busy_a), 64'd1);
  endtask

  task automatic pulse_show_a();
    @(negedge clk) show_a = 1'b1;
    @(negedge clk) show_a = 1'b0;
  endtask

  task automatic pulse_set_a(input logic [7:0] v);
    @(negedge clk) begin setv_a = 1'b1; setd_a = v; end
    @(negedge clk) setv_a = 1'b0;
    check("busnow_after_set", 64'(busnow_a), 64'(v));
  endtask

  initial begin
    int          n0, ns;
    logic [7:0]  cur, v, r;
    logic [63:0] e[$];

    repeat (5) @(negedge clk);
    check("rst_busnow", 64'(busnow_a), 64'd0);
    check("rst_utx", 64'(utx_a), 64'd1);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_fdone", 64'(fdone_a), 64'd0);
    check("rst_busnow_b", 64'(busnow_b), 64'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("load_busnow", 64'(busnow_a), 64'h3C);
    check("load_busnow_b", 64'(busnow_b), 64'h1234);
    wait_frames(0, 1);
    check("reset_frame", fa[0], mkframe(64'h3C, 1));

    // Write mid-frame: current frame keeps the old snapshot.
    pulse_show_a();
    wait_busy_a();
    repeat (1000) @(negedge clk);
    pulse_set_a(8'h81);
    wait_frames(0, 3);
    check("midset_old", fa[1], mkframe(64'h3C, 1));
    check("midset_new", fa[2], mkframe(64'h81, 1));

    // Three requests during one frame collapse into a single extra frame.
    n0 = fa.size();
    pulse_show_a();
    wait_busy_a();
    for (int i = 0; i < 3; i++) begin
      repeat (300) @(negedge clk);
      pulse_show_a();
    end
    wait_frames(0, n0 + 2);
    repeat (4000) @(negedge clk);
    check("single_extra", 64'(fa.size()), 64'(n0 + 2));
    check("extra_frame", fa[n0+1], mkframe(64'h81, 1));
    cur = 8'h81;

    for (int it = 0; it < 4; it++) begin
      e.delete();
      n0 = fa.size();
      v = 8'($urandom_range(0, 255));
      pulse_set_a(v);
      cur = v;
      e.push_back(mkframe(64'(v), 1));
      wait_busy_a();
      ns = 0;
      if ($urandom_range(0, 1) != 0) begin
        repeat ($urandom_range(100, 1500)) @(negedge clk);
        cur = 8'($urandom_range(0, 255));
        pulse_set_a(cur);
        ns++;
      end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        repeat (200) @(negedge clk);
        pulse_show_a();
        ns++;
      end
      if (ns > 0) e.push_back(mkframe(64'(cur), 1));
      wait_frames(0, n0 + e.size());
      for (int i = 0; i < e.size(); i++)
        check($sformatf("rnd%0d_f%0d", it, i), fa[n0+i], e[i]);
    end

    // Reset during the header data bits.
    pulse_show_a();
    wait_busy_a();
    repeat (300) @(negedge clk);
    @(posedge clk);
    #20 rst_a = 1'b1;
    #1;
    check("midrst_utx", 64'(utx_a), 64'd1);
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_busnow", 64'(busnow_a), 64'd0);
    repeat (5) @(negedge clk);
    n0 = fa.size();
    r = 8'($urandom_range(0, 255));
    busdef_a = r;
    rst_a = 1'b0;
    @(negedge clk);
    check("rerst_busnow", 64'(busnow_a), 64'(r));
    wait_frames(0, n0 + 1);
    check("rerst_frame", fa[n0], mkframe(64'(r), 1));

    // Two-byte instance: content of every frame and 5000-clock periodic spacing.
    check("b_nframes", 64'(fb.size() >= 3), 64'd1);
    for (int i = 0; i < fb.size(); i++) begin
      check($sformatf("b_frame%0d", i), fb[i], mkframe(64'h1234, 2));
      if (i >= 2) check($sformatf("b_period%0d", i), 64'(sb[i] - sb[i-1]), 64'd5000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_config_show_gen.md
# uart_config_show_gen

Parametrised configuration register with UART read-back. Holds a BUS_BYTES-wide configuration word, initialises it from `busDefault` after reset and lets a local master overwrite it. Reports the word as a framed 8N1 byte stream on `uTx`: on request, on every change, and periodically. Sits between board strap/default inputs and the debug UART pin; replaces the fixed-byte transmitter of the previous generation.

## Interface
- `BUS_BYTES`, 1: configuration width in bytes (1..8); bus width W = 8*BUS_BYTES.
- `CLK_HZ`, 10_000_000: `clk10mhz` frequency.
- `BAUD`, 115200: line rate; divisor DIV = round(CLK_HZ/BAUD) = 87 at defaults.
- `REPORT_PERIOD`, 1_000_000: clocks between periodic reports; 0 disables them.

Ports:
- `clk10mhz` in 1: the only clock; everything is clocked on its rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `busDefault` in W: value loaded into `busNow` after reset.
- `busNow` out W: current configuration.
- `setValid` in 1: one-cycle strobe that writes `setData`.
- `setData` in W: new configuration value.
- `showReq` in 1: one-cycle strobe that requests a report.
- `uTx` out 1: UART line, idle high.
- `txBusy` out 1: a frame is in progress.
- `frameDone` out 1: one-cycle pulse at the end of each frame.

## Operation
- Reset values: `busNow`=0, `uTx`=1, `txBusy`=0, `frameDone`=0, FSM=LOAD, `pending`=0, baud and period counters=0.
- LOAD, the first cycle after `rst` falls: `busNow`<=`busDefault` and `pending`<=1, then go to IDLE. If `setValid` is high in that cycle, `setData` wins.
- `setValid` in any later state: `busNow`<=`setData` next cycle and `pending`<=1. The frame in flight is unaffected.
- Trigger sources, OR-ed into `pending`:
  - `showReq`;
  - `setValid`;
  - the period counter reaching REPORT_PERIOD-1. The counter then wraps to 0 and counts continuously, including while busy.
- Multiple triggers collapse into a single pending frame.
- FSM: IDLE -> SNAP -> SEND -> IDLE.
  - IDLE: if `pending`, go to SNAP.
  - SNAP: copy `busNow` to the snapshot register, clear `pending` (a trigger arriving in the same cycle re-sets it), go to SEND.
  - SEND: serialise the frame bytes back to back.
  - Last stop bit complete: pulse `frameDone` and return to IDLE.
- Frame byte order: header 0xA5, then snapshot bytes most-significant byte first, then the checksum when enabled.
- Each byte is 8N1: start bit 0, data LSB first, stop bit 1. Every bit lasts exactly DIV clocks.
- `rst` mid-frame: `uTx` returns to 1 immediately (asynchronously); no partial byte resumes.

## Timing
- With IDLE and `pending` set at cycle t: SNAP at t, start bit of the header on `uTx` from t+1.
- `txBusy` rises at t+1 and falls after the final stop bit. `frameDone` is high for exactly that cycle; the next frame can start 1 cycle after `frameDone`.
- The baud counter restarts at every frame start, so bit edges occur at t+1+k*DIV.
- Frame length: (1+BUS_BYTES+C)*10*DIV clocks, where C=1 when the checksum is enabled, else 0.
  - Defaults with checksum: 3*870 = 2610 clocks.
- `busNow` updates 1 cycle after `setValid`; there is no handshake back-pressure.

## Configuration
- `UART_CFG_CHECKSUM_EN` defined: append a checksum byte = (sum of payload bytes) mod 256. The header is excluded.
- Not defined: the frame is header plus payload only, and C=0 in all timing formulas.

## Structure
- Shared package `uart_cfg_pkg`:
  - `CFG_HDR` = 8'hA5;
  - FSM state enum {LOAD, IDLE, SNAP, SEND};
  - function `baud_div(clk_hz, baud)` returning the rounded divisor.
- Sub-module `uart_tx_byte`:
  - ports: `clk10mhz`, `rst`, `start`, `data[7:0]`, `DIV` parameter;
  - outputs: `tx`, `busy`, `done` (one-cycle pulse);
  - owns its own baud counter.
- The top owns the FSM, the byte index (0..BUS_BYTES+C), the checksum accumulator, the snapshot, `busNow` and the period counter.

## Test plan
- Reset then release with `busDefault`=0x3C, BUS_BYTES=1, checksum on:
  - `busNow`=0x3C 1 cycle after release;
  - `uTx` carries A5,3C,3C;
  - `frameDone` at 2610 clocks after the start bit.
- `setValid` with `setData`=0x81 mid-frame:
  - the current frame still sends the old value;
  - the next frame is A5,81,81;
  - `busNow`=0x81 1 cycle after the strobe.
- `showReq` pulsed 3 times during one frame -> exactly one further frame follows.
- BUS_BYTES=2, `busDefault`=0x1234:
  - bytes A5,12,34,46;
  - each bit measured at 87 clocks;
  - start bit 0, stop bit 1.
- REPORT_PERIOD=5000 with no other traffic -> frames start every 5000 clocks; REPORT_PERIOD=0 -> no periodic frames.
- `rst` asserted during the data bits -> `uTx`=1, `txBusy`=0 and `busNow`=0 immediately; after release, a fresh reset frame is sent.
